// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: M-stage load/store sequencer for a variable-latency data
// memory. It stalls the pipeline while a request is outstanding, returns
// registered load data, flags timed-out accesses and counts completions.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] ReadDataM,
    output logic        MemStall,
    output logic        FlushW,
    output logic        mem_err,
    output logic [15:0] acc_count
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic [7:0] tmo_cnt;
    logic       acc;
    logic       tmo_hit;

    assign acc     = MemtoRegM | MemWriteM;
    assign tmo_hit = (tmo_cnt == TMO_LAST);
    assign FlushW  = MemStall;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and stall. DONE never stalls so the finished instruction
    // leaves M before a following access is considered.
    always_comb begin
        state_nx = state;
        MemStall = 1'b0;
        case (state)
            IDLE: begin
                MemStall = acc;
                if (acc) state_nx = REQ;
            end
            REQ: begin
                MemStall = 1'b1;
                if (mem_ready || tmo_hit) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, completion/timeout handling, read data and counters.
    // mem_we doubles as the load/store flag of the outstanding access, so a
    // load+store instruction is naturally handled as a store.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ReadDataM <= '0;
            mem_err   <= 1'b0;
            acc_count <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc) begin
                        mem_addr  <= ALUOutM;
                        mem_wdata <= WriteDataM;
                        mem_we    <= MemWriteM;
                        mem_req   <= 1'b1;
                        tmo_cnt   <= '0;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!mem_we) ReadDataM <= mem_rdata;
                        mem_req   <= 1'b0;
                        acc_count <= acc_count + 16'd1;
                    end else if (tmo_hit) begin
                        if (!mem_we) ReadDataM <= ERR_DATA;
                        mem_err <= 1'b1;
                        mem_req <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus pushes expected access
// results, a negedge monitor checks the request phase and the DONE cycle.
module tb_dmem_access_ctrl;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemtoRegM, MemWriteM, mem_ready;
    logic [31:0] ALUOutM, WriteDataM, mem_rdata;
    logic        mem_req, mem_we, MemStall, FlushW, mem_err;
    logic [31:0] mem_addr, mem_wdata, ReadDataM;
    logic [15:0] acc_count;

    dmem_access_ctrl #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ReadDataM(ReadDataM), .MemStall(MemStall), .FlushW(FlushW),
        .mem_err(mem_err), .acc_count(acc_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] cnt;
        int          req_n;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    bit          in_done = 1'b0;
    // reference state of the architectural outputs
    logic [31:0] m_rd  = '0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: request phase must match the head of the scoreboard; the
    // cycle where mem_req falls is DONE and carries the access result.
    int  req_n = 0, stall_n = 0;
    bit  prev_req = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("flushw_eq_stall", FlushW, MemStall);
            if (MemStall) stall_n++;
            if (mem_req) begin
                req_n++;
                if (sb.size() == 0) chk("spurious_req", 1, 0);
                else begin
                    chk("req_addr",  mem_addr,  sb[0].addr);
                    chk("req_wdata", mem_wdata, sb[0].wdata);
                    chk("req_we",    mem_we,    sb[0].we);
                end
            end
            if (prev_req && !mem_req && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("req_cycles",   req_n,     e.req_n);
                chk("stall_cycles", stall_n,   e.req_n + 1);
                chk("read_data",    ReadDataM, e.rdata);
                chk("mem_err",      mem_err,   e.err);
                chk("acc_count",    acc_count, e.cnt);
                req_n   = 0;
                stall_n = 0;
            end
            prev_req = mem_req;
        end
    end

    // One access; d = idle REQ cycles before mem_ready, d >= TO times out.
    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int d);
        exp_t e;
        bit   to;
        to = (d >= TO);
        MemtoRegM  = ld;
        MemWriteM  = st;
        ALUOutM    = a;
        WriteDataM = wd;
        mem_ready  = 1'b0;
        if (ld && !st) m_rd = to ? ERR : rd;
        if (to) m_err = 1'b1;
        else    m_cnt = m_cnt + 16'd1;
        e.we = st; e.addr = a; e.wdata = wd; e.rdata = m_rd;
        e.err = m_err; e.cnt = m_cnt; e.req_n = to ? TO : d + 1;
        sb.push_back(e);
        if (in_done) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        repeat (to ? TO : d) begin
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        if (!to) begin
            mem_ready = 1'b1;
            mem_rdata = rd;
            @(posedge clk); #1;
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
        in_done = 1'b1;
    endtask

    // Non-memory instructions; mem_ready noise must be ignored.
    task automatic gap(input int k);
        MemtoRegM = 1'b0;
        MemWriteM = 1'b0;
        repeat (k) begin
            ALUOutM   = $urandom;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        in_done   = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_readdata",  ReadDataM, 0);
        chk("rst_mem_err",   mem_err,   0);
        chk("rst_acc_count", acc_count, 0);
        chk("rst_stall",     MemStall,  0);
    endtask

    initial begin
        reset = 1'b1;
        MemtoRegM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0;
        ALUOutM = '0; WriteDataM = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // directed: zero-wait load, store completing on the last legal cycle,
        // back-to-back loads, load+store as store, then a timed-out load
        issue(1, 0, 32'h40, 32'h0, 32'h12345678, 0);
        gap(1);
        issue(0, 1, 32'h80, 32'hCAFEF00D, 32'h55555555, TO - 1);
        gap(2);
        issue(1, 0, 32'h100, 32'h0, 32'hA5A5A5A5, 0);
        issue(1, 0, 32'h104, 32'h0, 32'h5A5A5A5A, 0);
        issue(1, 1, 32'h200, 32'h11112222, 32'h99999999, 1);
        gap(1);
        issue(1, 0, 32'h300, 32'h0, 32'h77777777, TO + 1);
        gap(3);

        // random mix of loads, stores, delays, timeouts and gaps
        for (int i = 0; i < 300; i++) begin
            int   kind;
            logic ld, st;
            kind = $urandom_range(0, 2);
            ld = (kind != 1);
            st = (kind != 0);
            issue(ld, st, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
        end
        gap(3);
        chk("scoreboard_drained", sb.size(), 0);
        mon_en = 1'b0;

        // reset during the third REQ cycle of a load
        MemtoRegM = 1'b1; ALUOutM = 32'h44;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", mem_req, 1);
        MemtoRegM = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle_stall", MemStall, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences every load/store in the M stage of the pipelined MIPS core against a variable-latency data memory using a req/ready handshake. It freezes the pipeline while the access is outstanding and returns registered read data to the M/W boundary. It also flags accesses that never complete and counts completed accesses for performance monitoring. It sits between the M-stage control signals (MemtoRegM, MemWriteM) and the delayed data memory, alongside the hazard unit.

Parameters:
TIMEOUT, 64, number of REQ-state cycles without mem_ready before the access is aborted (range 1..255).
ERR_DATA, 32'hDEADBEEF, value loaded into ReadDataM when a load times out.

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
MemtoRegM  input  1  M-stage instruction is a load
MemWriteM  input  1  M-stage instruction is a store
ALUOutM  input  32  M-stage byte address
WriteDataM  input  32  M-stage store data
mem_ready  input  1  memory has completed the current request (rdata valid for loads)
mem_rdata  input  32  memory read data, valid only when mem_ready=1
mem_req  output  1  request to memory, registered
mem_we  output  1  1=write, 0=read, registered
mem_addr  output  32  latched address
mem_wdata  output  32  latched store data
ReadDataM  output  32  registered load result to M/W register
MemStall  output  1  stall F, D, E, M stages (combinational)
FlushW  output  1  bubble into W while M is stalled (equals MemStall)
mem_err  output  1  sticky timeout flag
acc_count  output  16  completed-access counter, wraps

Behaviour:
- Reset (async, any time, including mid-transaction) forces state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ReadDataM=0, mem_err=0, acc_count=0, and the timeout counter to 0. mem_req drops within the reset assertion and does not wait for a clock edge.
- The access signal is acc = MemtoRegM | MemWriteM.
- States: IDLE, REQ, DONE.
- IDLE:
  - MemStall = acc (combinational, same cycle).
  - If acc is high, on the next edge: latch mem_addr=ALUOutM, mem_wdata=WriteDataM, mem_we=MemWriteM; set mem_req=1; clear the timeout counter; go to REQ.
  - If MemtoRegM and MemWriteM are both high, the access is treated as a store.
- REQ:
  - MemStall=1; mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - If mem_ready=1: for a load, capture ReadDataM=mem_rdata (a store leaves ReadDataM unchanged); set mem_req=0; increment acc_count (modulo 2^16); go to DONE.
  - Otherwise, if the timeout counter equals TIMEOUT-1: set mem_err=1 (sticky until reset); for a load set ReadDataM=ERR_DATA; set mem_req=0; go to DONE. acc_count is not incremented.
  - Otherwise the timeout counter increments.
  - mem_ready takes priority over timeout in the same cycle.
- DONE:
  - MemStall=0 regardless of acc, so the completed instruction advances.
  - Unconditionally return to IDLE. A back-to-back access in the next M instruction is detected in IDLE on the following cycle.
- mem_ready is ignored outside REQ.
- Latency: with mem_ready high on the first REQ cycle, a load or store stalls 2 cycles (IDLE detect + REQ) and ReadDataM is valid in the DONE cycle. In general, stall cycles = 1 + number of REQ cycles.
- Non-memory instructions in M (acc=0) pass with zero stall.
- ReadDataM is held between accesses.

Test Plan:
- Reset mid-REQ: issue a load, assert reset during the 3rd REQ cycle -> mem_req=0 immediately, all outputs 0, state IDLE, acc_count=0.
- Zero-wait load: MemtoRegM=1, ALUOutM=0x40, mem_ready high the first REQ cycle with mem_rdata=0x12345678 -> MemStall high 2 cycles, mem_addr=0x40, mem_we=0, ReadDataM=0x12345678 in DONE, acc_count=1.
- Delayed store: MemWriteM=1, addr=0x80, data=0xCAFEF00D, mem_ready after 5 REQ cycles -> mem_req high exactly 5 cycles with stable addr/data, mem_we=1, MemStall high 6 cycles, ReadDataM unchanged.
- Back-to-back loads (2 consecutive M instructions, each 1-cycle ready) -> two distinct req pulses separated by DONE+IDLE, correct data each, acc_count=2; load+store both high -> mem_we=1.
- Timeout: TIMEOUT=4, load with mem_ready never asserted -> exactly 4 REQ cycles, mem_err=1, ReadDataM=0xDEADBEEF, acc_count unchanged; mem_ready arriving on the 4th cycle -> normal completion, mem_err=0.
- Counter wrap: 65536 completed accesses -> acc_count returns to 0; acc=0 instructions -> MemStall never asserted.
